instr_mem_responder: RTL and testbench
======================================

Name: instr_mem_responder

Overview:
- Memory-side responder for the instruction-fetch request interface: it answers req_valid/Addr with grant, then Data plus data_valid.
- Sits between the fetch unit and the instruction storage.
- Models a word-addressed instruction RAM with configurable read latency, flush-abort on request withdrawal, and a side load port for boot and bench preload.
- The load port has priority over fetch.

Parameters:
- ADDR_WIDTH, 32, byte-address width of the fetch port
- DATA_WIDTH, 32, instruction word width
- MEM_DEPTH, 1024, memory size in bytes; must be a multiple of 4; word count = MEM_DEPTH/4
- RD_LATENCY, 2, cycles from grant to first data_valid; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  fetch request; held high until the response is taken
- Addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] are ignored
- grant  out  1  one-cycle pulse accepting a request
- Data  out  DATA_WIDTH  instruction word; meaningful only while data_valid=1
- data_valid  out  1  response valid; held until req_valid drops
- ld_en  in  1  preload write strobe
- ld_addr  in  $clog2(MEM_DEPTH/4)  preload word index
- ld_data  in  DATA_WIDTH  preload word
- mem_busy  out  1  high when state is not IDLE or ld_en=1

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - grant=0, data_valid=0, Data=0, state=IDLE, latency counter=0, latched address=0.
  - Memory contents are not cleared.
- States: IDLE, GRANT, BUSY, RESP; 2-bit encoding.
- IDLE:
  - If req_valid=1 and ld_en=0: latch word index Addr[log2(MEM_DEPTH)-1:2], assert grant next cycle, go to GRANT.
  - If ld_en=1: stay in IDLE; the request waits, and grant is never issued in a load cycle.
- GRANT: grant=1 for exactly this cycle.
  - Counter is loaded with RD_LATENCY-1.
  - If req_valid=0, go to IDLE (abort).
  - Else if RD_LATENCY=1, go to RESP.
  - Else go to BUSY.
- BUSY: counter decrements each cycle.
  - If req_valid=0, go to IDLE (abort); no data_valid is ever produced for this request.
  - When counter=1 and req_valid=1, go to RESP.
- RESP entry: Data <= mem[latched index], read on the entry cycle.
  - A load to the same index in any earlier cycle is visible.
  - A load in the same cycle returns the old word (read-before-write).
- RESP: data_valid=1 and Data are held stable while req_valid=1.
  - When req_valid=0, go to IDLE; data_valid=0 from the next cycle.
  - Data keeps its last value.
- Latency: grant high at cycle T; data_valid first high at cycle T+RD_LATENCY.
- Back-to-back: a new request is granted no earlier than the cycle after IDLE re-entry. Minimum spacing between grants is RD_LATENCY+2 cycles.
- Address change while req_valid stays high after grant is ignored; the latched address is used.
- Address wrap: index bits above the memory size are discarded, so Addr=MEM_DEPTH maps to word 0.
- Load port:
  - ld_en writes mem[ld_addr] <= ld_data on the clock edge, in any state.
  - It blocks only new grants and does not stall BUSY or RESP.
- Reset mid-operation: state returns to IDLE immediately and all outputs drop asynchronously.

Optional Feature:
- Macro: IMEM_ADDR_CHECK_EN.
- When defined:
  - A request whose Addr[1:0]!=0 or Addr>=MEM_DEPTH is still granted and timed normally.
  - It returns Data=32'h00000013 (NOP) and asserts an extra output fetch_err=1, aligned with data_valid.
  - fetch_err resets to 0 and clears with data_valid.
- When undefined: no fetch_err port; low bits are ignored and the address wraps as above.

Decomposition:
- Shared package/header (system_param.vh style):
  - state encodings IMEM_IDLE/GRANT/BUSY/RESP
  - NOP constant 32'h00000013
  - word-index width derived from MEM_DEPTH
- One sub-module, instr_mem_array: single-port-read/single-port-write storage with synchronous write and read-before-write on the same index.
- The FSM, counter and handshake stay in the top.

Test Plan:
- Preload mem[5]=32'hDEADBEEF via ld port, then req_valid=1, Addr=0x14 with RD_LATENCY=2 -> grant pulse at T, data_valid=1 and Data=DEADBEEF at T+2, held until req_valid drops, then data_valid=0 next cycle.
- req_valid dropped in BUSY (flush) at T+1 -> no data_valid ever for that request; FSM returns to IDLE; a new request to 0x0 is granted normally.
- ld_en=1 held for 3 cycles while req_valid=1 -> grant withheld for those 3 cycles, issued on the first cycle after ld_en=0.
- Load to mem[5] on the RESP-entry cycle of a read of 0x14 -> old word returned; a repeat read returns the new word.
- Addr=MEM_DEPTH (0x400) with macro off -> returns mem[0]. With IMEM_ADDR_CHECK_EN on -> Data=0x00000013, fetch_err=1; Addr=0x6 -> same.
- Assert reset (low) while in RESP -> data_valid and grant go to 0 without a clock edge; after release, state is IDLE and the next request completes with correct data.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// Shared definitions for the instruction-memory responder: FSM state codes, NOP word, index-width helper.
package instr_mem_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE  = 2'd0,
        IMEM_GRANT = 2'd1,
        IMEM_BUSY  = 2'd2,
        IMEM_RESP  = 2'd3
    } imem_state_e;

    localparam logic [31:0] IMEM_NOP   = 32'h0000_0013;
    localparam int          IMEM_CNT_W = 4;

    function automatic int word_idx_w(input int mem_depth);
        return $clog2(mem_depth / 4);
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// Word-organised instruction storage: synchronous write, combinational read (old word on same-edge write).
module instr_mem_array #(
    parameter  int DATA_WIDTH = 32,
    parameter  int WORDS      = 256,
    localparam int AW         = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [WORDS];

    // NOTE: storage has no reset; clearing a RAM costs a port per word and boot preloads it anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_mem_responder.sv
// Fetch-side responder: grant, fixed-latency read, flush on request withdrawal, priority preload port.
// Optional IMEM_ADDR_CHECK_EN adds fetch_err and returns NOP for misaligned or out-of-range fetches.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    parameter  int MEM_DEPTH  = 1024,
    parameter  int RD_LATENCY = 2,
    localparam int WORD_AW    = word_idx_w(MEM_DEPTH),
    localparam int IDX_HI     = $clog2(MEM_DEPTH) - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] Addr,
    output logic                  grant,
    output logic [DATA_WIDTH-1:0] Data,
    output logic                  data_valid,
    input  logic                  ld_en,
    input  logic [WORD_AW-1:0]    ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
`ifdef IMEM_ADDR_CHECK_EN
    output logic                  fetch_err,
`endif
    output logic                  mem_busy
);

    imem_state_e           state_q, state_d;
    logic [IMEM_CNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_AW-1:0]    idx_q, idx_d;
    logic                  grant_q, grant_d;
    logic                  dvalid_q, dvalid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  enter_resp;

`ifdef IMEM_ADDR_CHECK_EN
    logic err_q, err_d;
    logic ferr_q, ferr_d;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{Addr[ADDR_WIDTH-1:IDX_HI+1], Addr[1:0]};
`endif

    instr_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .WORDS      (MEM_DEPTH / 4)
    ) u_array (
        .clk     (clk),
        .we      (ld_en),
        .wr_addr (ld_addr),
        .wr_data (ld_data),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        grant_d    = 1'b0;
        dvalid_d   = dvalid_q;
        data_d     = data_q;
        enter_resp = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
        err_d      = err_q;
        ferr_d     = ferr_q;
`endif
        case (state_q)
            IMEM_IDLE: begin
                if (req_valid && !ld_en) begin
                    idx_d   = Addr[IDX_HI:2];
                    grant_d = 1'b1;
                    state_d = IMEM_GRANT;
`ifdef IMEM_ADDR_CHECK_EN
                    err_d   = (Addr[1:0] != 2'b00) || (Addr >= ADDR_WIDTH'(MEM_DEPTH));
`endif
                end
            end
            IMEM_GRANT: begin
                cnt_d = IMEM_CNT_W'(RD_LATENCY - 1);
                if (!req_valid) begin
                    state_d = IMEM_IDLE;
                end else if (RD_LATENCY == 1) begin
                    state_d    = IMEM_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = IMEM_BUSY;
                end
            end
            IMEM_BUSY: begin
                cnt_d = cnt_q - IMEM_CNT_W'(1);
                if (!req_valid) begin
                    state_d = IMEM_IDLE;
                end else if (cnt_q == IMEM_CNT_W'(1)) begin
                    state_d    = IMEM_RESP;
                    enter_resp = 1'b1;
                end
            end
            IMEM_RESP: begin
                if (!req_valid) begin
                    state_d  = IMEM_IDLE;
                    dvalid_d = 1'b0;
`ifdef IMEM_ADDR_CHECK_EN
                    ferr_d   = 1'b0;
`endif
                end
            end
            default: state_d = IMEM_IDLE;
        endcase

        // The word is sampled on the edge that enters RESP, so a same-edge load still yields the old word.
        if (enter_resp) begin
            dvalid_d = 1'b1;
`ifdef IMEM_ADDR_CHECK_EN
            data_d   = err_q ? DATA_WIDTH'(IMEM_NOP) : rd_data;
            ferr_d   = err_q;
`else
            data_d   = rd_data;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in the comb block.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IMEM_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            grant_q  <= 1'b0;
            dvalid_q <= 1'b0;
            data_q   <= '0;
`ifdef IMEM_ADDR_CHECK_EN
            err_q    <= 1'b0;
            ferr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            grant_q  <= grant_d;
            dvalid_q <= dvalid_d;
            data_q   <= data_d;
`ifdef IMEM_ADDR_CHECK_EN
            err_q    <= err_d;
            ferr_q   <= ferr_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign data_valid = dvalid_q;
    assign Data       = data_q;
    assign mem_busy   = (state_q != IMEM_IDLE) || ld_en;
`ifdef IMEM_ADDR_CHECK_EN
    assign fetch_err  = ferr_q;
`endif

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: table-driven reads plus flush, load-priority, RAW and reset sequences.
module tb_instr_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] Addr;
    logic        grant;
    logic [31:0] Data;
    logic        data_valid;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        mem_busy;
`ifdef IMEM_ADDR_CHECK_EN
    logic        fetch_err;
`endif

    int checks = 0;
    int errors = 0;

    instr_mem_responder #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024),
        .RD_LATENCY (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .Addr       (Addr),
        .grant      (grant),
        .Data       (Data),
        .data_valid (data_valid),
        .ld_en      (ld_en),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
`ifdef IMEM_ADDR_CHECK_EN
        .fetch_err  (fetch_err),
`endif
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
    } ld_vec_t;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } rd_vec_t;

    ld_vec_t ld_tbl[4];
    rd_vec_t rd_tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] d);
        ld_en   = 1'b1;
        ld_addr = idx;
        ld_data = d;
        step();
        ld_en   = 1'b0;
    endtask

    // Full read from IDLE: grant next cycle, data LAT cycles later, held, cleared after withdrawal.
    task automatic do_read(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                           input logic exp_e);
        req_valid = 1'b1;
        Addr      = a;
        step();
        check({nm, " grant"}, grant, 1);
        check({nm, " busy"}, mem_busy, 1);
        Addr = a ^ 32'h0000_0008;
        for (int i = 1; i < LAT; i++) begin
            step();
            check({nm, " grant one cycle"}, grant, 0);
            check({nm, " no early valid"}, data_valid, 0);
        end
        step();
        check({nm, " valid"}, data_valid, 1);
        check({nm, " data"}, Data, exp_d);
`ifdef IMEM_ADDR_CHECK_EN
        check({nm, " fetch_err"}, fetch_err, exp_e);
`else
        check({nm, " err unused"}, exp_e, 0);
`endif
        step();
        check({nm, " valid held"}, data_valid, 1);
        check({nm, " data held"}, Data, exp_d);
        req_valid = 1'b0;
        step();
        check({nm, " valid drop"}, data_valid, 0);
        check({nm, " data kept"}, Data, exp_d);
`ifdef IMEM_ADDR_CHECK_EN
        check({nm, " err drop"}, fetch_err, 0);
`endif
    endtask

    initial begin
        logic saw_valid;

        ld_tbl[0] = '{8'd0,   32'hA0A0_0001};
        ld_tbl[1] = '{8'd5,   32'hDEAD_BEEF};
        ld_tbl[2] = '{8'd255, 32'h1234_5678};
        ld_tbl[3] = '{8'd1,   32'hCAFE_0001};

        rd_tbl[0] = '{"rd 0x14",  32'h0000_0014, 32'hDEAD_BEEF, 1'b0};
        rd_tbl[1] = '{"rd 0x0",   32'h0000_0000, 32'hA0A0_0001, 1'b0};
        rd_tbl[2] = '{"rd 0x3fc", 32'h0000_03FC, 32'h1234_5678, 1'b0};
        rd_tbl[3] = '{"rd 0x4",   32'h0000_0004, 32'hCAFE_0001, 1'b0};
`ifdef IMEM_ADDR_CHECK_EN
        rd_tbl[4] = '{"rd 0x400", 32'h0000_0400, 32'h0000_0013, 1'b1};
        rd_tbl[5] = '{"rd 0x6",   32'h0000_0006, 32'h0000_0013, 1'b1};
`else
        rd_tbl[4] = '{"rd 0x400", 32'h0000_0400, 32'hA0A0_0001, 1'b0};
        rd_tbl[5] = '{"rd 0x6",   32'h0000_0006, 32'hCAFE_0001, 1'b0};
`endif

        reset     = 1'b0;
        req_valid = 1'b0;
        Addr      = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        step();
        step();
        check("reset grant", grant, 0);
        check("reset valid", data_valid, 0);
        check("reset data", Data, 0);
        check("reset busy", mem_busy, 0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            ld_en   = 1'b1;
            ld_addr = ld_tbl[i].idx;
            ld_data = ld_tbl[i].data;
            #1;
            check("load busy", mem_busy, 1);
            step();
            ld_en = 1'b0;
        end

        for (int i = 0; i < 6; i++) begin
            do_read(rd_tbl[i].name, rd_tbl[i].addr, rd_tbl[i].exp_data, rd_tbl[i].exp_err);
        end

        // Withdraw in BUSY: no response may ever appear.
        req_valid = 1'b1;
        Addr      = 32'h14;
        step();
        check("flush grant", grant, 1);
        step();
        req_valid = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            saw_valid = saw_valid | data_valid;
        end
        check("flush no valid", saw_valid, 0);
        check("flush idle", mem_busy, 0);
        do_read("after flush", 32'h0, 32'hA0A0_0001, 1'b0);

        // Loads hold off the grant for as long as ld_en stays high.
        req_valid = 1'b1;
        Addr      = 32'h4;
        for (int i = 0; i < 3; i++) begin
            ld_en   = 1'b1;
            ld_addr = 8'(10 + i);
            ld_data = 32'h0000_1000 + 32'(i);
            step();
            check("ld blocks grant", grant, 0);
            check("ld keeps idle valid", data_valid, 0);
        end
        ld_en = 1'b0;
        step();
        check("grant after ld", grant, 1);
        for (int i = 0; i < LAT; i++) step();
        check("ld-delayed valid", data_valid, 1);
        check("ld-delayed data", Data, 32'hCAFE_0001);
        req_valid = 1'b0;
        step();
        do_read("rd loaded 10", 32'h28, 32'h0000_1000, 1'b0);
        do_read("rd loaded 12", 32'h30, 32'h0000_1002, 1'b0);

        // Same-edge load on the RESP-entry edge returns the old word.
        req_valid = 1'b1;
        Addr      = 32'h14;
        step();
        step();
        ld_en   = 1'b1;
        ld_addr = 8'd5;
        ld_data = 32'h5555_AAAA;
        step();
        ld_en = 1'b0;
        check("raw valid", data_valid, 1);
        check("raw old word", Data, 32'hDEAD_BEEF);
        req_valid = 1'b0;
        step();
        do_read("raw new word", 32'h14, 32'h5555_AAAA, 1'b0);

        // Asynchronous reset while in RESP.
        req_valid = 1'b1;
        Addr      = 32'h4;
        for (int i = 0; i <= LAT; i++) step();
        check("pre-reset valid", data_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("async rst valid", data_valid, 0);
        check("async rst grant", grant, 0);
        check("async rst data", Data, 0);
        check("async rst busy", mem_busy, 0);
        req_valid = 1'b0;
        #3;
        reset = 1'b1;
        step();
        check("post-reset idle", mem_busy, 0);
        do_read("post-reset rd", 32'h4, 32'hCAFE_0001, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
